// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: stereo I2S / left-justified serial transmitter.
// Bit clock is derived from sys_clock by a divider, so the block has a
// single clock domain. Frames enter a small FIFO via valid/ready and are
// serialised MSB-first with zero padding up to SLOT_W bits per channel.
// Optional feature macro: I2S_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_count output.
module i2s_tx_stereo #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LJ_MODE    = 0
) (
  input  logic                          sys_clock,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           in_left,
  input  logic [SAMPLE_W-1:0]           in_right,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          bit_clock,
  output logic                          word_clock,
  output logic                          data_bit,
`ifdef I2S_UNDERRUN_CNT_EN
  output logic                          underrun,
  output logic [15:0]                   underrun_count
`else
  output logic                          underrun
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int K_W   = $clog2(2 * SLOT_W);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * SLOT_W - 1);
  localparam logic [K_W-1:0]   K_SLOT   = K_W'(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Next frame bit index, wrapping at the end of the stereo frame.
  function automatic logic [K_W-1:0] k_next(input logic [K_W-1:0] k);
    logic [K_W-1:0] n;
    if (k == K_LAST) n = {K_W{1'b0}};
    else             n = k + K_W'(1);
    return n;
  endfunction

  // LRCK level while frame bit k is on the wire (I2S leads by one bit).
  function automatic logic wclk_for(input logic [K_W-1:0] k);
    logic w;
    if (LJ_MODE != 0) w = (k >= K_SLOT);
    else              w = (k_next(k) >= K_SLOT);
    return w;
  endfunction

  // Slot bit j of a sample, MSB first; positions past SAMPLE_W shift out as 0.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s,
                                    input logic [K_W-1:0]      j);
    logic [SAMPLE_W-1:0] sh;
    sh = s << j;
    return sh[SAMPLE_W-1];
  endfunction

  logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [K_W-1:0]        j_s;
  logic                  wclk_q, wclk_d;
  logic                  data_q, data_d;
  logic                  underrun_q, underrun_d;
  logic [SAMPLE_W-1:0]   left_q, left_d, right_q, right_d;
  logic                  push_s, pop_s, fall_s, frame_s;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0]           underrun_count_q, underrun_count_d;
`endif

  // Next-state logic: divider, frame sequencing, FIFO bookkeeping.
  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    k_d        = k_q;
    j_s        = k_q;
    wclk_d     = wclk_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;

    fall_s  = (div_q == DIV_LAST) && bclk_q;
    frame_s = fall_s && (k_q == K_LAST);
    pop_s   = frame_s && (level_q != {LVL_W{1'b0}});
    push_s  = in_valid && in_ready_q;

    if (div_q == DIV_LAST) begin
      div_d  = {DIV_W{1'b0}};
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end

    if (frame_s) begin
      if (pop_s) begin
        left_d   = mem_q[rd_ptr_q][2*SAMPLE_W-1:SAMPLE_W];
        right_d  = mem_q[rd_ptr_q][SAMPLE_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        left_d     = {SAMPLE_W{1'b0}};
        right_d    = {SAMPLE_W{1'b0}};
        underrun_d = 1'b1;
      end
    end else begin
      left_d = left_q;
    end

    if (fall_s) begin
      k_d    = k_next(k_q);
      wclk_d = wclk_for(k_d);
      if (k_d >= K_SLOT) begin
        j_s    = k_d - K_SLOT;
        data_d = slot_bit(right_d, j_s);
      end else begin
        j_s    = k_d;
        data_d = slot_bit(left_d, j_s);
      end
    end else begin
      k_d = k_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    in_ready_d = (level_d < LVL_FULL);
  end

`ifdef I2S_UNDERRUN_CNT_EN
  // Saturating count of underrun pulses.
  always_comb begin
    if (underrun_d && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_d = underrun_count_q + 16'd1;
    end else begin
      underrun_count_d = underrun_count_q;
    end
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      div_q      <= {DIV_W{1'b0}};
      bclk_q     <= 1'b0;
      k_q        <= K_LAST;
      wclk_q     <= (LJ_MODE != 0);
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      left_q     <= {SAMPLE_W{1'b0}};
      right_q    <= {SAMPLE_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      in_ready_q <= 1'b1;
`ifdef I2S_UNDERRUN_CNT_EN
      underrun_count_q <= 16'h0000;
`endif
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      k_q        <= k_d;
      wclk_q     <= wclk_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      left_q     <= left_d;
      right_q    <= right_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
`ifdef I2S_UNDERRUN_CNT_EN
      underrun_count_q <= underrun_count_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge sys_clock) begin
    if (!reset && push_s) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  assign in_ready   = in_ready_q;
  assign fifo_level = level_q;
  assign bit_clock  = bclk_q;
  assign word_clock = wclk_q;
  assign data_bit   = data_q;
  assign underrun   = underrun_q;
`ifdef I2S_UNDERRUN_CNT_EN
  assign underrun_count = underrun_count_q;
`endif

endmodule
